atm_ledger_arbiter: RTL and testbench

Shares one account ledger (balance register plus daily-withdrawal counter) between `N_TERM` ATM terminal front-ends, each running its own `atm_fsm` session. Grants one terminal at a time in round-robin order, validates each withdrawal against the balance and the daily limit, commits the debit, and returns a one-cycle completion status. Sits between the per-terminal session FSMs and the shared account storage.

---
 rtl/atm_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/atm_ledger_arbiter.sv | 135 +++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM ledger arbiter: FSM state, operation codes and
// completion error codes.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_COMMIT,
        ST_RESP,
        ST_RELEASE
    } state_t;

    localparam logic OP_INQ = 1'b0;
    localparam logic OP_WDR = 1'b1;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ZERO  = 2'd1;
    localparam logic [1:0] ERR_FUNDS = 2'd2;
    localparam logic [1:0] ERR_LIMIT = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: selects the first requester at or after
// ptr, wrapping modulo N_TERM.
module rr_arbiter #(
    parameter int N_TERM = 2,
    parameter int IDX_W  = 1
) (
    input  logic [N_TERM-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [N_TERM-1:0] pick,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [IDX_W:0] cand;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N_TERM; k++) begin
            // One extra bit so ptr + k cannot overflow before the wrap.
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_TERM))
                cand = cand - (IDX_W+1)'(N_TERM);
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                pick[cand[IDX_W-1:0]]   = 1'b1;
                idx                     = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shares one account ledger between N_TERM ATM terminals: round-robin grant,
// withdrawal validation against balance and daily limit, debit commit.
module atm_ledger_arbiter
    import atm_pkg::*;
#(
    parameter int N_TERM      = 2,
    parameter int AMT_W       = 16,
    parameter int INIT_BAL    = 20000,
    parameter int DAILY_LIMIT = 15000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_TERM-1:0]       req,
    input  logic [N_TERM-1:0]       op,
    input  logic [N_TERM*AMT_W-1:0] amt,
    input  logic                    day_rollover,
    output logic [N_TERM-1:0]       grant,
    output logic                    busy,
    output logic                    done,
    output logic                    ok,
    output logic [1:0]              err,
    output logic [AMT_W-1:0]        bal_out
);

    localparam int IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam logic [AMT_W:0]   LIMIT = (AMT_W+1)'(DAILY_LIMIT);
    localparam logic [AMT_W-1:0] BAL0  = AMT_W'(INIT_BAL);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_TERM - 1);

    state_t             state;
    logic [AMT_W-1:0]   balance;
    logic [AMT_W-1:0]   withdrawn;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   own_idx;
    logic               lat_op;
    logic [AMT_W-1:0]   lat_amt;
    logic               res_ok;
    logic [1:0]         res_err;

    logic [N_TERM-1:0]  pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [AMT_W:0]     wd_sum;

    rr_arbiter #(
        .N_TERM (N_TERM),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Carry bit kept so a large withdrawal cannot wrap past the limit check.
    assign wd_sum = {1'b0, withdrawn} + {1'b0, lat_amt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ok        <= 1'b0;
            err       <= ERR_NONE;
            bal_out   <= '0;
            balance   <= BAL0;
            withdrawn <= '0;
            rr_ptr    <= '0;
            own_idx   <= '0;
            lat_op    <= OP_INQ;
            lat_amt   <= '0;
            res_ok    <= 1'b0;
            res_err   <= ERR_NONE;
        end else begin
            done <= 1'b0;
            if (day_rollover)
                withdrawn <= '0;

            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant   <= pick;
                        own_idx <= pick_idx;
                        lat_op  <= op[pick_idx];
                        lat_amt <= amt[pick_idx*AMT_W +: AMT_W];
                        busy    <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    res_ok  <= 1'b0;
                    res_err <= ERR_NONE;
                    state   <= ST_RESP;
                    if (lat_op == OP_INQ)
                        res_ok <= 1'b1;
                    else if (lat_amt == '0)
                        res_err <= ERR_ZERO;
                    else if (lat_amt > balance)
                        res_err <= ERR_FUNDS;
                    else if (wd_sum > LIMIT)
                        res_err <= ERR_LIMIT;
                    else begin
                        res_ok <= 1'b1;
                        state  <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // A rollover landing here restarts the day with this debit.
                    balance   <= balance - lat_amt;
                    withdrawn <= day_rollover ? lat_amt : wd_sum[AMT_W-1:0];
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    done    <= 1'b1;
                    ok      <= res_ok;
                    err     <= res_err;
                    bal_out <= balance;
                    rr_ptr  <= (own_idx == LAST) ? '0 : own_idx + 1'b1;
                    state   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!req[own_idx]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench for atm_ledger_arbiter: directed scenarios plus a
// randomized phase, checked against an integer ledger model.
module tb_atm_ledger_arbiter;

    localparam int N     = 2;
    localparam int AW    = 16;
    localparam int INIT  = 20000;
    localparam int LIMIT = 15000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    op;
    logic [N*AW-1:0] amt;
    logic            day_rollover;
    logic [N-1:0]    grant;
    logic            busy;
    logic            done;
    logic            ok;
    logic [1:0]      err;
    logic [AW-1:0]   bal_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference ledger state
    int m_bal, m_wd, m_ptr;
    int op_v [N];
    int amt_v[N];

    atm_ledger_arbiter #(
        .N_TERM      (N),
        .AMT_W       (AW),
        .INIT_BAL    (INIT),
        .DAILY_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .amt          (amt),
        .day_rollover (day_rollover),
        .grant        (grant),
        .busy         (busy),
        .done         (done),
        .ok           (ok),
        .err          (err),
        .bal_out      (bal_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick_model(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ok"}, 32'(ok), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_bal"}, 32'(bal_out), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        day_rollover = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        m_bal = INIT; m_wd = 0; m_ptr = 0;
    endtask

    task automatic drive(input int t, input int o, input int a);
        op_v[t]  = o;
        amt_v[t] = a;
        op[t]    = o[0];
        amt[t*AW +: AW] = AW'(a);
        req[t]   = 1'b1;
    endtask

    task automatic pulse_rollover();
        @(negedge clk);
        day_rollover = 1'b1;
        @(negedge clk);
        day_rollover = 1'b0;
        m_wd = 0;
    endtask

    // Serve terminal t whose req is already up; roll_edge >= 0 pulses
    // day_rollover so that it is sampled at that edge of the transaction.
    task automatic serve_one(input int t, input int roll_edge);
        int e_ok, e_err, e_lat, debit, a;
        bit seen;
        a = amt_v[t];
        debit = 0;
        e_ok = 0; e_err = 0; e_lat = 2;
        if (op_v[t] == 0)               e_ok = 1;
        else if (a == 0)                e_err = 1;
        else if (a > m_bal)             e_err = 2;
        else if (m_wd + a > LIMIT)      e_err = 3;
        else begin e_ok = 1; e_lat = 3; debit = a; end
        m_bal = m_bal - debit;
        m_wd  = (roll_edge >= 0) ? debit : m_wd + debit;
        m_ptr = (t + 1) % N;

        seen = 1'b0;
        for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
            day_rollover = (cyc == roll_edge);
            @(negedge clk);
            if (cyc == 0) begin
                chk("grant_owner", 32'(grant), 32'(1 << t));
                chk("busy_high", 32'(busy), 1);
                // Inputs after the grant must not affect the result.
                op[t] = ~op[t];
                amt[t*AW +: AW] = AW'($urandom);
            end
            if (done) begin
                seen = 1'b1;
                chk("latency", 32'(cyc), 32'(e_lat));
                chk("ok", 32'(ok), 32'(e_ok));
                chk("err", 32'(err), 32'(e_err));
                chk("bal_out", 32'(bal_out), 32'(m_bal));
            end
        end
        day_rollover = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 0);
        chk("grant_held", 32'(grant), 32'(1 << t));
        req[t] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (grant == '0) begin
                seen = 1'b1;
                chk("release_lat", 32'(k), 0);
                chk("busy_low", 32'(busy), 0);
            end
        end
        if (!seen) chk("release_timeout", 0, 1);
    endtask

    function automatic int rand_amt();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return m_bal;
            2:       return m_bal + 1;
            3:       return LIMIT - m_wd;
            4:       return LIMIT - m_wd + 1;
            default: return int'($urandom_range(1, 4000));
        endcase
    endfunction

    initial begin
        int w, t, roll;
        rst = 1'b1;
        req = '0;
        op = '0;
        amt = '0;
        day_rollover = 1'b0;
        #1;
        check_reset_outputs("por");
        do_reset();

        // Balance and daily-limit walk on terminal 0
        drive(0, 1, 10000); serve_one(0, -1);
        drive(0, 1, 5000);  serve_one(0, -1);
        drive(0, 1, 1000);  serve_one(0, -1);
        pulse_rollover();
        drive(0, 1, 6000);  serve_one(0, -1);
        drive(0, 1, 0);     serve_one(0, -1);
        drive(0, 0, 0);     serve_one(0, -1);

        // Both terminals from reset: 0 first, then 1
        do_reset();
        @(negedge clk);
        drive(0, 1, 1000);
        drive(1, 1, 1000);
        w = pick_model(req);
        chk("rr_first", 32'(w), 0);
        serve_one(w, -1);
        serve_one(1 - w, -1);

        // Rollover coincident with a COMMIT
        do_reset();
        drive(0, 1, 10000); serve_one(0, -1);
        drive(1, 1, 4000);  serve_one(1, 2);
        drive(0, 1, 6001);  serve_one(0, -1);
        drive(1, 1, 6000);  serve_one(1, -1);

        // Asynchronous reset while in CHECK
        @(negedge clk);
        drive(0, 1, 3000);
        @(negedge clk);
        chk("pre_rst_grant", 32'(grant), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        m_bal = INIT; m_wd = 0; m_ptr = 0;
        @(negedge clk);
        drive(1, 0, 0); serve_one(1, -1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (m_bal < 2000) do_reset();
            if ($urandom_range(0, 9) == 0) pulse_rollover();
            roll = ($urandom_range(0, 5) == 0) ? 2 : -1;
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                drive(0, ($urandom_range(0, 4) == 0) ? 0 : 1, rand_amt());
                drive(1, ($urandom_range(0, 4) == 0) ? 0 : 1, rand_amt());
                w = pick_model(req);
                serve_one(w, roll);
                serve_one(1 - w, -1);
            end else begin
                t = int'($urandom_range(0, N - 1));
                drive(t, ($urandom_range(0, 4) == 0) ? 0 : 1, rand_amt());
                serve_one(t, roll);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
